// File: rtl/pipeline_ctrl_pkg.sv
// Shared processor definitions for the issue controller: register-field
// widths, default sizing, FSM encoding and the latency normalisation helper.
package pipeline_ctrl_pkg;

  localparam int NREG_DEF   = 8;
  localparam int MAXLAT_DEF = 3;
  localparam int REG_W      = 3;
  localparam int LAT_W      = 2;
  localparam int CNT_W      = 2;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_BR_WAIT = 2'd1,
    ST_FLUSH   = 2'd2
  } state_t;

  // A latency of 0 means single-cycle; anything beyond the slowest unit is
  // clamped so a counter can never outlive the real execution pipe.
  function automatic logic [CNT_W-1:0] eff_lat(input logic [LAT_W-1:0] lat,
                                               input int               maxlat);
    logic [CNT_W-1:0] l;
    l = (lat == '0) ? CNT_W'(1) : CNT_W'(lat);
    if (int'(l) > maxlat) l = CNT_W'(maxlat);
    return l;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_scoreboard.sv
// Register scoreboard: one countdown per architectural register, the busy
// mask derived from those counters, and the RAW/WAW hazard compare for the
// instruction currently sitting in decode.
module pipeline_ctrl_scoreboard
  import pipeline_ctrl_pkg::*;
#(
  parameter int NREG   = NREG_DEF,
  parameter int MAXLAT = MAXLAT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic             rs2_used,
  input  logic [REG_W-1:0] rd,
  input  logic             rd_we,
  input  logic [LAT_W-1:0] lat,
  input  logic             load,
  output logic [NREG-1:0]  busy_mask,
  output logic             hazard
);

  logic [CNT_W-1:0] cnt [NREG];

  // Load the destination counter on a writing issue (never for r0); every
  // other pending counter counts down regardless of pipeline state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (i != 0 && load && rd == REG_W'(i))
          cnt[i] <= eff_lat(lat, MAXLAT);
        else if (cnt[i] != '0)
          cnt[i] <= cnt[i] - CNT_W'(1);
      end
    end
  end

  // Busy mask is a pure function of the counter flops; r0 is tied clear.
  always_comb begin
    busy_mask = '0;
    for (int i = 1; i < NREG; i++) busy_mask[i] = (cnt[i] != '0);
  end

  // Hazard when any operand actually read, or the written rd, is pending.
  always_comb begin
    hazard = busy_mask[rs1]
           | (rs2_used & busy_mask[rs2])
           | (rd_we & busy_mask[rd]);
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Issue controller: combines scoreboard hazards with a branch-resolution FSM
// to hold decode, flags the flush on a taken branch and counts stall cycles.
//
// Handshake: decode presents an instruction with dec_valid; it is consumed on
// the rising edge where issue=1 (issue = dec_valid & ~stall). While stall=1
// decode must hold the same instruction; with dec_valid=0 neither is raised.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int NREG   = NREG_DEF,
  parameter int MAXLAT = MAXLAT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dec_valid,
  input  logic [REG_W-1:0] dec_rs1,
  input  logic [REG_W-1:0] dec_rs2,
  input  logic             dec_rs2_used,
  input  logic [REG_W-1:0] dec_rd,
  input  logic             dec_rd_we,
  input  logic [LAT_W-1:0] dec_lat,
  input  logic             dec_is_branch,
  input  logic             ex_br_resolved,
  input  logic             ex_br_taken,
  output logic             stall,
  output logic             issue,
  output logic             is_branch_taken,
  output logic [NREG-1:0]  busy_mask,
  output logic [15:0]      stall_cnt,
  output state_t           dbg_state
);

  state_t state, state_nxt;
  logic   hazard;

  pipeline_ctrl_scoreboard #(.NREG(NREG), .MAXLAT(MAXLAT)) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .rs1       (dec_rs1),
    .rs2       (dec_rs2),
    .rs2_used  (dec_rs2_used),
    .rd        (dec_rd),
    .rd_we     (dec_rd_we),
    .lat       (dec_lat),
    .load      (issue & dec_rd_we),
    .busy_mask (busy_mask),
    .hazard    (hazard)
  );

  assign stall           = dec_valid & (hazard | (state != ST_RUN));
  assign issue           = dec_valid & ~stall;
  assign is_branch_taken = (state == ST_FLUSH);
  assign dbg_state       = state;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_RUN;
    else       state <= state_nxt;
  end

  // Next state: a branch blocks issue until execute resolves it; a taken
  // branch spends exactly one cycle in FLUSH. Resolution is only looked at
  // in BR_WAIT, so a report in the branch's own issue cycle is ignored.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:     if (issue && dec_is_branch) state_nxt = ST_BR_WAIT;
      ST_BR_WAIT: if (ex_br_resolved) state_nxt = ex_br_taken ? ST_FLUSH : ST_RUN;
      ST_FLUSH:   state_nxt = ST_RUN;
      default:    state_nxt = ST_RUN;
    endcase
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              stall_cnt <= '0;
    else if (stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: each driven cycle pushes its hand-derived
// expected outputs; a negedge monitor pops and compares.
module tb_pipeline_ctrl;
  import pipeline_ctrl_pkg::*;

  localparam int W = 27; // {stall, issue, is_branch_taken, busy_mask[7:0], stall_cnt[15:0]}

  logic       clk = 1'b0;
  logic       reset;
  logic       dec_valid, dec_rs2_used, dec_rd_we, dec_is_branch;
  logic [2:0] dec_rs1, dec_rs2, dec_rd;
  logic [1:0] dec_lat;
  logic       ex_br_resolved, ex_br_taken;
  logic       stall, issue, is_branch_taken;
  logic [7:0] busy_mask;
  logic [15:0] stall_cnt;
  state_t     dbg_state;

  logic [W-1:0] exp_q[$];
  int           id_q[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  int           step    = 0;
  logic [15:0]  exp_cnt = '0;

  pipeline_ctrl dut (
    .clk(clk), .reset(reset),
    .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rs2_used(dec_rs2_used), .dec_rd(dec_rd), .dec_rd_we(dec_rd_we),
    .dec_lat(dec_lat), .dec_is_branch(dec_is_branch),
    .ex_br_resolved(ex_br_resolved), .ex_br_taken(ex_br_taken),
    .stall(stall), .issue(issue), .is_branch_taken(is_branch_taken),
    .busy_mask(busy_mask), .stall_cnt(stall_cnt), .dbg_state(dbg_state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  // Driver: apply one decode cycle and record what the outputs must be in it.
  task automatic cyc(input logic v, input logic [2:0] rs1, input logic [2:0] rs2,
                     input logic rs2u, input logic [2:0] rd, input logic we,
                     input logic [1:0] lat, input logic br, input logic res,
                     input logic tkn, input logic e_stall, input logic e_issue,
                     input logic e_ibt, input logic [7:0] e_bm);
    dec_valid = v; dec_rs1 = rs1; dec_rs2 = rs2; dec_rs2_used = rs2u;
    dec_rd = rd; dec_rd_we = we; dec_lat = lat; dec_is_branch = br;
    ex_br_resolved = res; ex_br_taken = tkn;
    exp_q.push_back({e_stall, e_issue, e_ibt, e_bm, exp_cnt});
    id_q.push_back(step);
    step++;
    if (e_stall && exp_cnt != 16'hFFFF) exp_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [7:0] e_bm);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e_bm);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Monitor / scoreboard
  logic [W-1:0] m_exp, m_got;
  int           m_id;
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      m_exp = exp_q.pop_front();
      m_id  = id_q.pop_front();
      m_got = {stall, issue, is_branch_taken, busy_mask, stall_cnt};
      n_tests++;
      if (m_got !== m_exp) begin
        n_fail++;
        $display("FAIL step%0d: got stall=%b issue=%b ibt=%b busy_mask=%h stall_cnt=%0d, expected stall=%b issue=%b ibt=%b busy_mask=%h stall_cnt=%0d",
                 m_id, m_got[26], m_got[25], m_got[24], m_got[23:16], m_got[15:0],
                 m_exp[26], m_exp[25], m_exp[24], m_exp[23:16], m_exp[15:0]);
      end
    end
  end

  initial begin
    reset = 1'b1;
    dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rs2_used = 0; dec_rd = 0;
    dec_rd_we = 0; dec_lat = 0; dec_is_branch = 0; ex_br_resolved = 0; ex_br_taken = 0;
    #2;
    chk("reset_outputs", {20'd0, stall, issue, is_branch_taken, busy_mask},  32'd0);
    chk("reset_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("reset_state", {30'd0, dbg_state}, {30'd0, ST_RUN});
    @(posedge clk);
    #1 reset = 1'b0;

    idle(8'h00);
    // RAW: rd=3 lat=2 then rs1=3 -> two stalls, issue on the third cycle
    cyc(1, 1, 2, 1, 3, 1, 2, 0, 0, 0, 0, 1, 0, 8'h00);
    cyc(1, 3, 0, 0, 4, 1, 1, 0, 0, 0, 1, 0, 0, 8'h08);
    cyc(1, 3, 0, 0, 4, 1, 1, 0, 0, 0, 1, 0, 0, 8'h08);
    cyc(1, 3, 0, 0, 4, 1, 1, 0, 0, 0, 0, 1, 0, 8'h00);
    // Immediate form: rs2=3 busy but unused -> issues; used -> stalls
    cyc(1, 0, 0, 0, 3, 1, 3, 0, 0, 0, 0, 1, 0, 8'h10);
    cyc(1, 1, 3, 0, 2, 0, 0, 0, 0, 0, 0, 1, 0, 8'h08);
    cyc(1, 1, 3, 1, 2, 0, 0, 0, 0, 0, 1, 0, 0, 8'h08);
    idle(8'h08);
    idle(8'h00);
    // WAW on r5 with lat=3, then an r0 write that must never mark busy
    cyc(1, 0, 0, 0, 5, 1, 3, 0, 0, 0, 0, 1, 0, 8'h00);
    repeat (3) cyc(1, 0, 0, 0, 5, 1, 1, 0, 0, 0, 1, 0, 0, 8'h20);
    cyc(1, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 1, 0, 8'h00);
    cyc(1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 1, 0, 8'h20);
    idle(8'h00);
    // Taken branch; resolve in the issue cycle is ignored
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 1, 0, 8'h00);
    repeat (4) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8'h00);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 8'h00);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 8'h00);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 8'h00);
    // Not-taken branch
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 8'h00);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 8'h00);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 8'h00);
    idle(8'h00);
    // lat=0 behaves as single-cycle
    cyc(1, 0, 0, 0, 6, 1, 0, 0, 0, 0, 0, 1, 0, 8'h00);
    cyc(1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8'h40);
    cyc(1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 8'h00);
    // Reset in BR_WAIT with r2/r3 pending
    cyc(1, 0, 0, 0, 2, 1, 3, 0, 0, 0, 0, 1, 0, 8'h00);
    cyc(1, 0, 0, 0, 3, 1, 3, 1, 0, 0, 0, 1, 0, 8'h04);
    idle(8'h0C);
    chk("pre_reset_state", {30'd0, dbg_state}, {30'd0, ST_BR_WAIT});
    #2 reset = 1'b1;
    #1;
    chk("async_reset_outputs", {20'd0, stall, issue, is_branch_taken, busy_mask}, 32'd0);
    chk("async_reset_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("async_reset_state", {30'd0, dbg_state}, {30'd0, ST_RUN});
    @(posedge clk);
    #1 reset = 1'b0;
    exp_cnt = '0;
    repeat (2) cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 8'h00);
    cyc(1, 2, 0, 0, 3, 1, 1, 0, 0, 0, 0, 1, 0, 8'h00);
    idle(8'h08);
    idle(8'h00);

    @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter NREG, default 8, number of architectural registers (3-bit specifiers).
REQ-002 SHALL have parameter MAXLAT, default 3, largest execution latency in cycles.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port dec_valid  input  1  decode holds a valid decoded instruction this cycle.
REQ-006 SHALL have port dec_rs1  input  3  first source register.
REQ-007 SHALL have port dec_rs2  input  3  second source register.
REQ-008 SHALL have port dec_rs2_used  input  1  rs2 read; low for immediate-form instructions (imm_flag set).
REQ-009 SHALL have port dec_rd  input  3  destination register.
REQ-010 SHALL have port dec_rd_we  input  1  instruction writes rd.
REQ-011 SHALL have port dec_lat  input  2  execution latency 1..3; value 0 treated as 1.
REQ-012 SHALL have port dec_is_branch  input  1  instruction is a conditional branch.
REQ-013 SHALL have port ex_br_resolved  input  1  execute reports branch outcome this cycle.
REQ-014 SHALL have port ex_br_taken  input  1  outcome, qualified by ex_br_resolved.
REQ-015 SHALL have port stall  output  1  holds decode; combinational.
REQ-016 SHALL have port issue  output  1  instruction accepted this cycle; combinational.
REQ-017 SHALL have port is_branch_taken  output  1  flush to fetch/decode; registered.
REQ-018 SHALL have port busy_mask  output  8  bit i set while register i is pending; registered.
REQ-019 SHALL have port stall_cnt  output  16  saturating count of cycles with stall high.

Function
REQ-020 SHALL keep one 2-bit countdown per register; register busy while its counter is non-zero; busy_mask mirrors this.
REQ-021 SHALL treat register 0 as never busy; issues with dec_rd=0 do not load a counter.
REQ-022 SHALL flag a hazard when dec_rs1 is busy, or when dec_rs2_used and dec_rs2 is busy, or when dec_rd_we and dec_rd is busy (WAW).
REQ-023 SHALL drive stall = dec_valid & (hazard | state != RUN); issue = dec_valid & ~stall.
REQ-024 SHALL, on an issue edge with dec_rd_we, load the counter of dec_rd with dec_lat (0 -> 1); all other non-zero counters decrement by 1.
REQ-025 SHALL give a load priority over a decrement for the same register in the same cycle.
REQ-026 SHALL implement FSM states RUN, BR_WAIT and FLUSH.
REQ-027 SHALL transition RUN -> BR_WAIT on an issue edge with dec_is_branch; otherwise remain in RUN.
REQ-028 SHALL ignore ex_br_resolved outside BR_WAIT, including in the cycle the branch itself issues.
REQ-029 SHALL transition BR_WAIT -> FLUSH on ex_br_resolved & ex_br_taken, BR_WAIT -> RUN on ex_br_resolved & ~ex_br_taken, and otherwise remain in BR_WAIT.
REQ-030 SHALL transition FLUSH -> RUN unconditionally after one cycle.
REQ-031 SHALL drive is_branch_taken high for exactly the one cycle the FSM is in FLUSH.
REQ-032 SHALL keep scoreboard counters decrementing in every state, so that a flush does not cancel older writes.
REQ-033 SHALL increment stall_cnt on every cycle with stall high and hold it at 16'hFFFF once saturated.

Reset
REQ-034 SHALL, on reset assertion and independent of clk, clear all counters, set busy_mask=0, state=RUN, is_branch_taken=0 and stall_cnt=0.
REQ-035 SHALL drive stall=0 and issue=0 whenever dec_valid=0, including during and immediately after reset.
REQ-036 SHALL discard an in-flight BR_WAIT when reset is asserted mid-operation; no flush is emitted afterwards.

Structure
REQ-037 SHALL take the FSM state encoding, NREG, MAXLAT and register-field width from the shared processor package.
REQ-038 SHALL contain one sub-module, scoreboard, holding the counters, busy_mask and hazard compare; the FSM and stall_cnt stay in the top module.

Verification
REQ-039 SHALL cover RAW: issue rd=3 with lat=2, then rs1=3 on the next cycle -> stall for 2 cycles, issue on the 3rd; busy_mask=8'h08 then 8'h08 then 8'h00.
REQ-040 SHALL cover immediate form: rs2=3 busy with dec_rs2_used=0 and rs1=1 free -> no stall, issue=1.
REQ-041 SHALL cover a taken branch: issue a branch, hold 4 cycles, then ex_br_resolved=1 and ex_br_taken=1 -> stall=1 throughout BR_WAIT, is_branch_taken=1 for one cycle, issue resumes in the cycle after.
REQ-042 SHALL cover a not-taken branch: resolve with ex_br_taken=0 -> is_branch_taken never rises, issue in the next cycle.
REQ-043 SHALL cover WAW and r0: issue rd=5 lat=3, then rd=5 -> stalls until counter 0; rd=0 writes never set busy_mask[0].
REQ-044 SHALL cover reset mid-operation: assert reset in BR_WAIT with busy_mask=8'h0C -> outputs cleared asynchronously, RUN after release, stall_cnt=0.
